noc_local_ni: RTL and testbench

- Network interface between a processing element (PE) and the local port of a mesh router.
- TX side: packs PE requests into 32-bit flits and injects them into the router's local input, honouring the router's local full flag.
- RX side: accepts flits delivered by the router's local output, which has no backpressure. It checks the destination, buffers the flits and hands them to the PE over a valid/ready handshake.

---
 rtl/noc_local_ni_pkg.sv | 26 ++
 rtl/noc_local_ni_fifo.sv | 61 ++++++
 rtl/noc_local_ni.sv | 168 ++++++++++++++++
 tb/tb_noc_local_ni.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_local_ni_pkg.sv
// Shared constants for the local network interface: flit geometry and
// field positions. Flit layout is {payload[31:6], src[5:3], dst[2:0]}.
package noc_local_ni_pkg;

   localparam int DATA_WIDTH    = 32;
   localparam int ADDR_WIDTH    = 3;
   localparam int PAYLOAD_WIDTH = 26;

   localparam int DST_LSB     = 0;
   localparam int SRC_LSB     = 3;
   localparam int PAYLOAD_LSB = 6;

   // RX entries keep only what the PE sees: {payload, src}
   localparam int RX_WIDTH = PAYLOAD_WIDTH + ADDR_WIDTH;

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   function automatic logic [DATA_WIDTH-1:0] pack_flit(
      input logic [PAYLOAD_WIDTH-1:0] payload,
      input logic [ADDR_WIDTH-1:0]    src,
      input logic [ADDR_WIDTH-1:0]    dst
   );
      return {payload, src, dst};
   endfunction

endpackage

// File: rtl/noc_local_ni_fifo.sv
// ni_sync_fifo: width/depth parameterised synchronous FIFO, async high reset.
// Ports: clk, rst, push_i/data_i (write), pop_i (read), head_o, empty_o, full_o.
module ni_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign head_o  = mem_q[rd_ptr_q];

   // a full queue may still take a push when it is popped on the same edge
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // storage needs no reset: contents are only visible through head_o
   // qualified by !empty_o
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/noc_local_ni.sv
// Local network interface between a PE and the local port of a mesh router.
// TX: tx_valid/tx_ready/tx_dst/tx_payload -> NOC_DATA_OUT/NOC_DATA_VALID_OUT,
//     throttled by NOC_FULL_IN.
// RX: NOC_DATA_IN/NOC_DATA_VALID_IN (no backpressure) -> rx_valid/rx_ready/
//     rx_src/rx_payload; drops raise sticky rx_overflow/rx_misroute (err_clr).
// Statistics tx_cnt/rx_cnt/drop_cnt are built only with NI_STATS_EN defined;
// otherwise they read as zero.
module noc_local_ni
   import noc_local_ni_pkg::*;
#(
   parameter logic [ADDR_WIDTH-1:0] NODE_ADDRESS = 3'b000,
   parameter int TX_DEPTH = 4,
   parameter int RX_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   input  logic [ADDR_WIDTH-1:0]    tx_dst,
   input  logic [PAYLOAD_WIDTH-1:0] tx_payload,
   output logic [DATA_WIDTH-1:0]    NOC_DATA_OUT,
   output logic                     NOC_DATA_VALID_OUT,
   input  logic                     NOC_FULL_IN,
   input  logic [DATA_WIDTH-1:0]    NOC_DATA_IN,
   input  logic                     NOC_DATA_VALID_IN,
   output logic                     rx_valid,
   input  logic                     rx_ready,
   output logic [ADDR_WIDTH-1:0]    rx_src,
   output logic [PAYLOAD_WIDTH-1:0] rx_payload,
   input  logic                     err_clr,
   output logic                     rx_overflow,
   output logic                     rx_misroute,
   output logic [15:0]              tx_cnt,
   output logic [15:0]              rx_cnt,
   output logic [15:0]              drop_cnt
);

   // ---------------- TX path ----------------
   logic [DATA_WIDTH-1:0] txq_head;
   logic                  txq_empty;
   logic                  txq_full;
   logic                  tx_push;
   logic                  tx_pop;

   assign tx_ready = !txq_full;
   assign tx_push  = tx_valid && !txq_full;
   assign tx_pop   = !txq_empty && !NOC_FULL_IN;

   ni_sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (TX_DEPTH)
   ) u_txq (
      .clk     (clk),
      .rst     (rst),
      .push_i  (tx_push),
      .data_i  (pack_flit(tx_payload, NODE_ADDRESS, tx_dst)),
      .pop_i   (tx_pop),
      .head_o  (txq_head),
      .empty_o (txq_empty),
      .full_o  (txq_full)
   );

   assign NOC_DATA_VALID_OUT = tx_pop;
   assign NOC_DATA_OUT       = txq_empty ? '0 : txq_head;

   // ---------------- RX path ----------------
   logic [ADDR_WIDTH-1:0] in_dst;
   logic [RX_WIDTH-1:0]   rxq_head;
   logic                  rxq_empty;
   logic                  rxq_full;
   logic                  rx_pop;
   logic                  rx_push;
   logic                  drop_mis;
   logic                  drop_ovf;

   assign in_dst   = NOC_DATA_IN[DST_LSB +: ADDR_WIDTH];
   assign rx_pop   = rx_valid && rx_ready;
   assign drop_mis = NOC_DATA_VALID_IN && (in_dst != NODE_ADDRESS);
   // a same-edge PE pop frees the slot, so only a non-popping full queue drops
   assign drop_ovf = NOC_DATA_VALID_IN && !drop_mis && rxq_full && !rx_pop;
   assign rx_push  = NOC_DATA_VALID_IN && !drop_mis && !drop_ovf;

   ni_sync_fifo #(
      .WIDTH (RX_WIDTH),
      .DEPTH (RX_DEPTH)
   ) u_rxq (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rx_push),
      .data_i  (NOC_DATA_IN[DATA_WIDTH-1:SRC_LSB]),
      .pop_i   (rx_pop),
      .head_o  (rxq_head),
      .empty_o (rxq_empty),
      .full_o  (rxq_full)
   );

   assign rx_valid   = !rxq_empty;
   assign rx_src     = rxq_empty ? '0 : rxq_head[ADDR_WIDTH-1:0];
   assign rx_payload = rxq_empty ? '0 : rxq_head[RX_WIDTH-1:ADDR_WIDTH];

   // ---------------- sticky error flags ----------------
   logic ovf_q, ovf_d;
   logic mis_q, mis_d;

   // clear wins over a set on the same edge
   always_comb begin
      ovf_d = ovf_q || drop_ovf;
      mis_d = mis_q || drop_mis;
      if (err_clr) begin
         ovf_d = 1'b0;
         mis_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
         mis_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         mis_q <= mis_d;
      end
   end

   assign rx_overflow = ovf_q;
   assign rx_misroute = mis_q;

   // ---------------- statistics ----------------
`ifdef NI_STATS_EN
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   // saturating counters
   always_comb begin
      tx_cnt_d   = tx_cnt_q;
      rx_cnt_d   = rx_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (tx_pop && tx_cnt_q != CNT_MAX)
         tx_cnt_d = tx_cnt_q + 16'd1;
      if (rx_push && rx_cnt_q != CNT_MAX)
         rx_cnt_d = rx_cnt_q + 16'd1;
      if ((drop_mis || drop_ovf) && drop_cnt_q != CNT_MAX)
         drop_cnt_d = drop_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_cnt_q   <= '0;
         rx_cnt_q   <= '0;
         drop_cnt_q <= '0;
      end else begin
         tx_cnt_q   <= tx_cnt_d;
         rx_cnt_q   <= rx_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign tx_cnt   = tx_cnt_q;
   assign rx_cnt   = rx_cnt_q;
   assign drop_cnt = drop_cnt_q;
`else
   assign tx_cnt   = 16'h0000;
   assign rx_cnt   = 16'h0000;
   assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_noc_local_ni.sv
// Directed bench for noc_local_ni (NODE_ADDRESS = 3'b010) with
// scoreboard queues for the TX and RX streams.
module tb_noc_local_ni;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_valid;
   logic        tx_ready;
   logic [2:0]  tx_dst;
   logic [25:0] tx_payload;
   logic [31:0] NOC_DATA_OUT;
   logic        NOC_DATA_VALID_OUT;
   logic        NOC_FULL_IN;
   logic [31:0] NOC_DATA_IN;
   logic        NOC_DATA_VALID_IN;
   logic        rx_valid;
   logic        rx_ready;
   logic [2:0]  rx_src;
   logic [25:0] rx_payload;
   logic        err_clr;
   logic        rx_overflow;
   logic        rx_misroute;
   logic [15:0] tx_cnt;
   logic [15:0] rx_cnt;
   logic [15:0] drop_cnt;

   localparam logic [2:0] ME = 3'b010;

   noc_local_ni #(
      .NODE_ADDRESS (ME),
      .TX_DEPTH     (4),
      .RX_DEPTH     (4)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .tx_valid           (tx_valid),
      .tx_ready           (tx_ready),
      .tx_dst             (tx_dst),
      .tx_payload         (tx_payload),
      .NOC_DATA_OUT       (NOC_DATA_OUT),
      .NOC_DATA_VALID_OUT (NOC_DATA_VALID_OUT),
      .NOC_FULL_IN        (NOC_FULL_IN),
      .NOC_DATA_IN        (NOC_DATA_IN),
      .NOC_DATA_VALID_IN  (NOC_DATA_VALID_IN),
      .rx_valid           (rx_valid),
      .rx_ready           (rx_ready),
      .rx_src             (rx_src),
      .rx_payload         (rx_payload),
      .err_clr            (err_clr),
      .rx_overflow        (rx_overflow),
      .rx_misroute        (rx_misroute),
      .tx_cnt             (tx_cnt),
      .rx_cnt             (rx_cnt),
      .drop_cnt           (drop_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int strobes = 0;

   logic [31:0] tx_exp [$];
   logic [28:0] rx_exp [$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // scoreboard monitors, sampled on the falling edge
   always @(negedge clk) begin
      if (!rst) begin
         if (NOC_FULL_IN)
            chk("no_strobe_when_full", {31'd0, NOC_DATA_VALID_OUT}, 32'd0);
         if (NOC_DATA_VALID_OUT) begin
            strobes++;
            chk("tx_sb_has_entry", {31'd0, tx_exp.size() != 0}, 32'd1);
            if (tx_exp.size() != 0)
               chk("tx_sb_flit", NOC_DATA_OUT, tx_exp.pop_front());
         end
         if (rx_valid && rx_ready) begin
            chk("rx_sb_has_entry", {31'd0, rx_exp.size() != 0}, 32'd1);
            if (rx_exp.size() != 0)
               chk("rx_sb_flit", {3'd0, rx_payload, rx_src},
                   {3'd0, rx_exp.pop_front()});
         end
      end
   end

   task automatic deliver(input logic [31:0] flit);
      NOC_DATA_IN       = flit;
      NOC_DATA_VALID_IN = 1'b1;
      tick();
      NOC_DATA_VALID_IN = 1'b0;
      NOC_DATA_IN       = '0;
   endtask

   initial begin
      int s0;
      logic [25:0] pl;
      rst = 1'b1;
      tx_valid = 1'b0;
      tx_dst = '0;
      tx_payload = '0;
      NOC_FULL_IN = 1'b0;
      NOC_DATA_IN = '0;
      NOC_DATA_VALID_IN = 1'b0;
      rx_ready = 1'b0;
      err_clr = 1'b0;

      // 1. reset then idle
      tick_n(2);
      @(negedge clk);
      chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      chk("rst_strobe", {31'd0, NOC_DATA_VALID_OUT}, 32'd0);
      chk("rst_data_out", NOC_DATA_OUT, 32'd0);
      chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_rx_fields", {3'd0, rx_payload, rx_src}, 32'd0);
      chk("rst_flags", {30'd0, rx_overflow, rx_misroute}, 32'd0);
      chk("rst_cnts", {tx_cnt, drop_cnt}, 32'd0);
      rst = 1'b0;
      tick_n(2);
      @(negedge clk);
      chk("idle_strobe", {31'd0, NOC_DATA_VALID_OUT}, 32'd0);
      chk("idle_tx_ready", {31'd0, tx_ready}, 32'd1);
      tick();

      // 2. single request
      tx_valid   = 1'b1;
      tx_dst     = 3'b101;
      tx_payload = 26'h0ABCDE;
      tx_exp.push_back(32'h02AF3795);
      tick();
      tx_valid = 1'b0;
      @(negedge clk);
      chk("t2_strobe", {31'd0, NOC_DATA_VALID_OUT}, 32'd1);
      chk("t2_data", NOC_DATA_OUT, 32'h02AF3795);
      tick();
      @(negedge clk);
      chk("t2_one_cycle", {31'd0, NOC_DATA_VALID_OUT}, 32'd0);
      tick();

      // 3. router full, 5 requests, then release
      NOC_FULL_IN = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pl = 26'h100 + 26'(i);
         tx_valid   = 1'b1;
         tx_dst     = 3'(i);
         tx_payload = pl;
         @(negedge clk);
         chk($sformatf("t3_ready_%0d", i), {31'd0, tx_ready},
             {31'd0, i < 4});
         if (i < 4) tx_exp.push_back({pl, ME, 3'(i)});
         tick();
      end
      tx_valid = 1'b0;
      tick_n(2);
      chk("t3_held", {31'd0, tx_exp.size() == 4}, 32'd1);
      s0 = strobes;
      NOC_FULL_IN = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("t3_burst_%0d", i),
             {31'd0, NOC_DATA_VALID_OUT}, 32'd1);
         tick();
      end
      @(negedge clk);
      chk("t3_burst_end", {31'd0, NOC_DATA_VALID_OUT}, 32'd0);
      chk("t3_strobe_count", 32'(strobes - s0), 32'd4);
      chk("t3_tx_sb_empty", 32'(tx_exp.size()), 32'd0);
      chk("t3_tx_ready", {31'd0, tx_ready}, 32'd1);
`ifdef NI_STATS_EN
      chk("t3_tx_cnt", {16'd0, tx_cnt}, 32'd5);
`else
      chk("t3_tx_cnt_off", {16'd0, tx_cnt}, 32'd0);
`endif
      tick();

      // 4. single RX flit, PE not ready
      rx_exp.push_back({26'h11, 3'b010});
      deliver(32'h00000452);
      @(negedge clk);
      chk("t4_rx_valid", {31'd0, rx_valid}, 32'd1);
      chk("t4_rx_src", {29'd0, rx_src}, 32'd2);
      chk("t4_rx_payload", {6'd0, rx_payload}, 32'h11);
      tick();

      // 5. fill RX and overflow
      for (int i = 0; i < 3; i++) begin
         pl = 26'h21 + 26'(i);
         rx_exp.push_back({pl, 3'b011});
         deliver({pl, 3'b011, ME});
      end
      deliver({26'h3FF, 3'b001, ME});
      @(negedge clk);
      chk("t5_overflow", {31'd0, rx_overflow}, 32'd1);
      chk("t5_no_misroute", {31'd0, rx_misroute}, 32'd0);
      chk("t5_head_kept", {6'd0, rx_payload}, 32'h11);
`ifdef NI_STATS_EN
      chk("t5_drop_cnt", {16'd0, drop_cnt}, 32'd1);
      chk("t5_rx_cnt", {16'd0, rx_cnt}, 32'd4);
`else
      chk("t5_drop_cnt_off", {16'd0, drop_cnt}, 32'd0);
`endif
      tick();
      // same flit again while the PE pops: accepted
      rx_ready = 1'b1;
      rx_exp.push_back({26'h3FF, 3'b001});
      deliver({26'h3FF, 3'b001, ME});
      rx_ready = 1'b0;
      @(negedge clk);
      chk("t5_still_full", 32'(rx_exp.size()), 32'd4);
      chk("t5_head_next", {6'd0, rx_payload}, 32'h21);
      rx_ready = 1'b1;
      tick_n(6);
      rx_ready = 1'b0;
      @(negedge clk);
      chk("t5_rx_sb_empty", 32'(rx_exp.size()), 32'd0);
      chk("t5_drained", {31'd0, rx_valid}, 32'd0);
      chk("t5_idle_fields", {3'd0, rx_payload, rx_src}, 32'd0);
      chk("t5_overflow_sticky", {31'd0, rx_overflow}, 32'd1);
      tick();

      // 6. misroute, err_clr, clear priority
      rx_exp.push_back({26'h2A, 3'b100});
      deliver({26'h2A, 3'b100, ME});
      deliver({26'h55, 3'b000, 3'b111});
      @(negedge clk);
      chk("t6_misroute", {31'd0, rx_misroute}, 32'd1);
      chk("t6_not_queued", {6'd0, rx_payload}, 32'h2A);
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      @(negedge clk);
      chk("t6_cleared", {30'd0, rx_overflow, rx_misroute}, 32'd0);
      chk("t6_rx_valid_kept", {31'd0, rx_valid}, 32'd1);
      tick();
      err_clr = 1'b1;
      deliver({26'h66, 3'b000, 3'b111});
      err_clr = 1'b0;
      @(negedge clk);
      chk("t6_clr_priority", {31'd0, rx_misroute}, 32'd0);
`ifdef NI_STATS_EN
      chk("t6_drop_cnt", {16'd0, drop_cnt}, 32'd3);
`endif
      rx_ready = 1'b1;
      tick_n(2);
      rx_ready = 1'b0;
      @(negedge clk);
      chk("t6_rx_sb_empty", 32'(rx_exp.size()), 32'd0);
      tick();

      // reset mid-transfer discards queued flits
      NOC_FULL_IN = 1'b1;
      tx_valid = 1'b1;
      tx_dst = 3'b001;
      tx_payload = 26'h77;
      tick_n(2);
      tx_valid = 1'b0;
      rst = 1'b1;
      tx_exp.delete();
      tick();
      rst = 1'b0;
      NOC_FULL_IN = 1'b0;
      s0 = strobes;
      tick_n(3);
      chk("rst_mid_no_resend", 32'(strobes - s0), 32'd0);
      chk("rst_mid_cnt", {16'd0, tx_cnt}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
